// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus arbiter: FSM encoding, default sizing
// and the round-robin pointer advance helper.
package dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TURN  = 2'd2
    } dbus_state_e;

    localparam int unsigned DBUS_NUM_MASTERS = 4;
    localparam int unsigned DBUS_QUANTUM     = 16;
    localparam int unsigned DBUS_QCNT_W      = 8;

    // Pointer value after granting master k out of n (wraps to 0).
    function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
        return ((k + 1) >= n) ? 0 : (k + 1);
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping around, reported as one-hot, index and any-valid.
module rr_pick #(
    parameter int unsigned P_N = 4
) (
    input  logic [P_N-1:0]         i_Req,
    input  logic [$clog2(P_N)-1:0] i_Ptr,
    output logic [P_N-1:0]         o_Gnt,
    output logic [$clog2(P_N)-1:0] o_Idx,
    output logic                   o_Any
);

    localparam int unsigned IW = $clog2(P_N);

    int unsigned          cand;
    logic [IW-1:0]        cand_idx;

    always_comb begin
        o_Gnt    = '0;
        o_Idx    = '0;
        o_Any    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < int'(P_N); i++) begin
            // Pointer is always below P_N, so one subtraction replaces a modulo.
            cand = 32'(i_Ptr) + 32'(i);
            if (cand >= P_N) begin
                cand = cand - P_N;
            end
            cand_idx = cand[IW-1:0];
            if (!o_Any && i_Req[cand_idx]) begin
                o_Any          = 1'b1;
                o_Idx          = cand_idx;
                o_Gnt[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin DBus arbiter with a one-cycle turnaround between owners.
// Optional time-quantum preemption is enabled by defining DBUS_ARB_QUANTUM_EN.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int unsigned P_NUM_MASTERS = DBUS_NUM_MASTERS,
    parameter int unsigned P_QUANTUM     = DBUS_QUANTUM
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst_n,
    input  logic [P_NUM_MASTERS-1:0]         i_Req,
    input  logic [P_NUM_MASTERS-1:0]         i_Lock,
    output logic [P_NUM_MASTERS-1:0]         o_Gnt,
    output logic                             o_GntValid,
    output logic [$clog2(P_NUM_MASTERS)-1:0] o_GntId,
    output logic                             o_BusIdle,
    output dbus_state_e                      o_DbgState
);

    localparam int unsigned IW = $clog2(P_NUM_MASTERS);

    dbus_state_e              state_q, state_d;
    logic [P_NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IW-1:0]            id_q, id_d;
    logic [IW-1:0]            ptr_q, ptr_d;

    logic [P_NUM_MASTERS-1:0] pick_gnt;
    logic [IW-1:0]            pick_idx;
    logic                     pick_any;
    logic                     owner_req;
    logic                     owner_lock;
    logic                     quantum_hit;

    rr_pick #(
        .P_N (P_NUM_MASTERS)
    ) u_pick (
        .i_Req (i_Req),
        .i_Ptr (ptr_q),
        .o_Gnt (pick_gnt),
        .o_Idx (pick_idx),
        .o_Any (pick_any)
    );

    assign owner_req  = i_Req[id_q];
    assign owner_lock = i_Lock[id_q];

`ifdef DBUS_ARB_QUANTUM_EN
    logic [DBUS_QCNT_W-1:0] qcnt_q, qcnt_d;
    logic                   others_req;

    assign others_req  = |(i_Req & ~gnt_q);
    assign quantum_hit = (state_q == ST_OWNED) &&
                         (qcnt_q >= DBUS_QCNT_W'(P_QUANTUM - 1)) &&
                         others_req && !owner_lock;

    // Counts owned cycles of the current tenure; saturates rather than wraps.
    always_comb begin
        qcnt_d = qcnt_q;
        if (state_q == ST_OWNED && qcnt_q != {DBUS_QCNT_W{1'b1}}) begin
            qcnt_d = qcnt_q + 1'b1;
        end
        if (state_q != ST_OWNED && state_d == ST_OWNED) begin
            qcnt_d = '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            qcnt_q <= '0;
        end else begin
            qcnt_q <= qcnt_d;
        end
    end
`else
    assign quantum_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            // TURN re-arbitrates exactly like IDLE; it only differs in name
            // so the forced idle cycle is visible on the debug port.
            ST_IDLE, ST_TURN: begin
                gnt_d = '0;
                id_d  = '0;
                if (pick_any) begin
                    state_d = ST_OWNED;
                    gnt_d   = pick_gnt;
                    id_d    = pick_idx;
                    ptr_d   = IW'(rr_next(32'(pick_idx), P_NUM_MASTERS));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                // Lock keeps the bus across a dropped request (RMW gap).
                if ((!owner_req && !owner_lock) || quantum_hit) begin
                    state_d = ST_TURN;
                    gnt_d   = '0;
                    id_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_Gnt      = gnt_q;
    assign o_GntValid = |gnt_q;
    assign o_GntId    = id_q;
    assign o_BusIdle  = ~|gnt_q;
    assign o_DbgState = state_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: directed grant sequences plus a random
// phase checking one-hot grants and the turnaround gap between owners.
module tb_dbus_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic              i_Clk = 1'b0;
    logic              i_Rst_n;
    logic [N-1:0]      i_Req;
    logic [N-1:0]      i_Lock;
    logic [N-1:0]      o_Gnt;
    logic              o_GntValid;
    logic [IW-1:0]     o_GntId;
    logic              o_BusIdle;
    dbus_pkg::dbus_state_e o_DbgState;

    logic [N-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 i_Clk = ~i_Clk;

    dbus_arbiter #(
        .P_NUM_MASTERS (N),
        .P_QUANTUM     (16)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Req      (i_Req),
        .i_Lock     (i_Lock),
        .o_Gnt      (o_Gnt),
        .o_GntValid (o_GntValid),
        .o_GntId    (o_GntId),
        .o_BusIdle  (o_BusIdle),
        .o_DbgState (o_DbgState)
    );

    function automatic logic [IW-1:0] idx_of(input logic [N-1:0] g);
        idx_of = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) idx_of = IW'(i);
        end
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs; expected grant is what the DUT shows after the edge.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] lock,
                        input logic [N-1:0] exp_gnt);
        i_Req  = req;
        i_Lock = lock;
        @(posedge i_Clk);
        #1;
        exp_q.push_back(exp_gnt);
    endtask

    // Monitor: pops expectations and checks bus-contention invariants.
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] e;
    always @(negedge i_Clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt",      8'(o_Gnt),      8'(e));
            chk("gntvalid", 8'(o_GntValid), 8'(|e));
            chk("gntid",    8'(o_GntId),    8'(idx_of(e)));
            chk("busidle",  8'(o_BusIdle),  8'(~|e));
        end
        if (i_Rst_n) begin
            chk("onehot0", 8'($onehot0(o_Gnt)), 8'd1);
            chk("idle_vs_valid", 8'(o_BusIdle), 8'(!o_GntValid));
            if (prev_gnt != '0 && o_Gnt != '0) begin
                chk("turnaround", 8'(o_Gnt), 8'(prev_gnt));
            end
        end
        prev_gnt = o_Gnt;
    end

    initial begin
        logic [N-1:0] oh;
        logic [N-1:0] r;
        logic [N-1:0] ex;

        i_Rst_n = 1'b0;
        i_Req   = 4'b1111;
        i_Lock  = 4'b0000;
        repeat (2) begin
            @(posedge i_Clk);
            #1;
            exp_q.push_back(4'b0000);
        end
        i_Rst_n = 1'b1;
        step(4'b1111, 4'b0000, 4'b0001);

        // Fairness: each owner keeps the bus three cycles then releases.
        for (int m = 0; m < N; m++) begin
            oh = 4'b0001 << m;
            step(4'b1111, 4'b0000, oh);
            step(4'b1111, 4'b0000, oh);
            step(4'b1111 & ~oh, 4'b0000, 4'b0000);
            oh = 4'b0001 << ((m + 1) % N);
            step(4'b1111, 4'b0000, oh);
        end

        // Lock: master 2 keeps the grant across a two-cycle request gap.
        step(4'b0100, 4'b0000, 4'b0000);
        step(4'b0100, 4'b0000, 4'b0100);
        step(4'b0100, 4'b0100, 4'b0100);
        step(4'b0000, 4'b0100, 4'b0100);
        step(4'b0000, 4'b0100, 4'b0100);
        step(4'b0100, 4'b0100, 4'b0100);
        step(4'b1111, 4'b0100, 4'b0100);
        step(4'b1011, 4'b0000, 4'b0000);
        step(4'b1011, 4'b0000, 4'b1000);
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);

        // Simultaneous requests resolved from the pointer, with wrap-around.
        step(4'b0110, 4'b0000, 4'b0010);
        step(4'b0100, 4'b0000, 4'b0000);
        step(4'b0100, 4'b0000, 4'b0100);
        step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0001);

        // Quantum: master 0 owns, master 1 starts requesting in owned cycle 3.
        for (int k = 2; k <= 24; k++) begin
            r = (k - 1 >= 3) ? 4'b0011 : 4'b0001;
`ifdef DBUS_ARB_QUANTUM_EN
            ex = (k <= 16) ? 4'b0001 : ((k == 17) ? 4'b0000 : 4'b0010);
`else
            ex = 4'b0001;
`endif
            step(r, 4'b0000, ex);
        end
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset while master 2 owns the bus.
        step(4'b0100, 4'b0000, 4'b0100);
        i_Req = 4'b0100;
        @(posedge i_Clk);
        #2;
        i_Rst_n = 1'b0;
        exp_q.push_back(4'b0000);
        i_Req = 4'b1111;
        @(posedge i_Clk);
        #1;
        exp_q.push_back(4'b0000);
        #2;
        i_Rst_n = 1'b1;
        step(4'b1111, 4'b0000, 4'b0001);
        step(4'b1111, 4'b0000, 4'b0001);

        // Random phase: only the contention invariants are checked.
        for (int c = 0; c < 300; c++) begin
            i_Req  = 4'($urandom_range(0, 15));
            i_Lock = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            @(posedge i_Clk);
            #1;
        end
        i_Req  = 4'b0000;
        i_Lock = 4'b0000;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge i_Clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
